// File: rtl/regfile_burst_reader.sv
// regfile_burst_reader
// Read-side sequencer for a small register file. On Start it walks a
// contiguous, wrapping range of register addresses through the file's
// synchronous read port. Each word is offered on a valid/ready stream.
// Out_last marks the final word, and Done pulses once the burst has drained.
//
// Ports
//   Clock       rising-edge system clock
//   Clear       asynchronous active-low reset
//   Start       burst request, only looked at while idle
//   First_addr  first register address of the burst (sampled with Start)
//   Count       number of registers to read (sampled with Start, clamped
//               to the file depth)
//   Rd_en       register file read enable
//   Rd_addr     register file read address
//   Rd_data     register file read data, valid the cycle after Rd_en
//   Out_data    streamed word
//   Out_valid   Out_data holds a word for the consumer
//   Out_ready   consumer accepts the word
//   Out_last    current word is the last of the burst
//   Busy        sequencer is not idle
//   Done        single-cycle pulse when the burst completes
module regfile_burst_reader #(
    parameter int N      = 4,
    parameter int ADDR_W = 3
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Start,
    input  logic [ADDR_W-1:0] First_addr,
    input  logic [ADDR_W:0]   Count,
    output logic              Rd_en,
    output logic [ADDR_W-1:0] Rd_addr,
    input  logic [N-1:0]      Rd_data,
    output logic [N-1:0]      Out_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic              Out_last,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        FINISH
    } state_t;

    // The file holds 2^ADDR_W words. Count has one extra bit, so the
    // depth itself is representable and larger requests clamp to it.
    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [N-1:0]        data_q, data_d;

    // Next-state logic. The sequence for each word is a single ISSUE
    // cycle, then one CAPTURE cycle while the file answers, then SEND
    // until the consumer takes the word. The address register is
    // ADDR_W bits wide, so the increment wraps naturally at the top of
    // the file.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Count == '0) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = First_addr;
                        rem_d   = (Count > DEPTH) ? DEPTH : Count;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = Rd_data;
                state_d = SEND;
            end
            SEND: begin
                if (Out_ready) begin
                    if (rem_q == REM_ONE) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        rem_d   = rem_q - REM_ONE;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any burst in flight.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    // Every output is decoded from registered state only. Because of that,
    // an asynchronous reset clears the outputs at once, and no input
    // reaches an output through combinational logic.
    assign Rd_en     = (state_q == ISSUE);
    assign Rd_addr   = addr_q;
    assign Out_data  = data_q;
    assign Out_valid = (state_q == SEND);
    assign Out_last  = (state_q == SEND) && (rem_q == REM_ONE);
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == FINISH);

endmodule

// File: tb/tb_regfile_burst_reader.sv
// tb_regfile_burst_reader
// Bench for regfile_burst_reader. It holds a register file model preloaded
// with reg[i] = 15 - i. A cycle-timed reference model predicts, for every
// cycle, when the read strobe fires, when each word becomes valid, what the
// word is, and when Done pulses. Directed bursts are also compared against
// hand-computed sequences.
module tb_regfile_burst_reader;

    localparam int N      = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              Clock;
    logic              Clear;
    logic              Start;
    logic [ADDR_W-1:0] First_addr;
    logic [ADDR_W:0]   Count;
    logic              Rd_en;
    logic [ADDR_W-1:0] Rd_addr;
    logic [N-1:0]      Rd_data;
    logic [N-1:0]      Out_data;
    logic              Out_valid;
    logic              Out_ready;
    logic              Out_last;
    logic              Busy;
    logic              Done;

    regfile_burst_reader #(.N(N), .ADDR_W(ADDR_W)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .Start      (Start),
        .First_addr (First_addr),
        .Count      (Count),
        .Rd_en      (Rd_en),
        .Rd_addr    (Rd_addr),
        .Rd_data    (Rd_data),
        .Out_data   (Out_data),
        .Out_valid  (Out_valid),
        .Out_ready  (Out_ready),
        .Out_last   (Out_last),
        .Busy       (Busy),
        .Done       (Done)
    );

    // Clock generation.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Register file with a synchronous read port.
    logic [N-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'(15 - i);
    end
    always @(posedge Clock) begin
        if (Rd_en) Rd_data <= mem[Rd_addr];
    end

    // Cycle counter. Cycle k is the interval that follows rising edge k.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Logs of what the DUT actually did, used by the directed checks.
    int rd_addr_log[$];
    int rd_cyc_log[$];
    int valid_cyc_log[$];
    int valid_data_log[$];
    int hs_data_log[$];
    int hs_last_log[$];
    int hs_cyc_log[$];
    int done_cyc_log[$];

    task automatic clearLogs();
        rd_addr_log.delete();
        rd_cyc_log.delete();
        valid_cyc_log.delete();
        valid_data_log.delete();
        hs_data_log.delete();
        hs_last_log.delete();
        hs_cyc_log.delete();
        done_cyc_log.delete();
    endtask

    // The reference model is kept as event times. It records the cycle of
    // the next read strobe, the cycle from which the current word is valid,
    // the cycle of the Done pulse, the current address, and the number of
    // words left.
    int m_busy      = 0;
    int m_rd_cyc    = -1;
    int m_valid_frm = -1;
    int m_done_cyc  = -1;
    int m_addr      = 0;
    int m_left      = 0;
    int e_rd, e_valid, e_last, e_done, e_busy, e_data, c;

    // Compare process. It runs at the falling edge, while inputs and
    // outputs are both stable. It checks the DUT against the prediction
    // for this cycle, then advances the model to the next rising edge.
    always @(negedge Clock) begin
        if (!Clear) begin
            m_busy      = 0;
            m_rd_cyc    = -1;
            m_valid_frm = -1;
            m_done_cyc  = -1;
            m_addr      = 0;
            m_left      = 0;
        end else begin
            c       = cyc;
            e_rd    = (c == m_rd_cyc) ? 1 : 0;
            e_valid = (m_valid_frm >= 0 && c >= m_valid_frm) ? 1 : 0;
            e_last  = (e_valid == 1 && m_left == 1) ? 1 : 0;
            e_data  = 15 - m_addr;
            e_done  = (c == m_done_cyc) ? 1 : 0;
            e_busy  = m_busy;

            checkOutput("rd_en", Rd_en, e_rd);
            if (e_rd == 1) checkOutput("rd_addr", Rd_addr, m_addr);
            checkOutput("out_valid", Out_valid, e_valid);
            checkOutput("out_last", Out_last, e_last);
            if (e_valid == 1) checkOutput("out_data", Out_data, e_data);
            checkOutput("busy", Busy, e_busy);
            checkOutput("done", Done, e_done);

            if (Rd_en) begin
                rd_addr_log.push_back(Rd_addr);
                rd_cyc_log.push_back(c);
            end
            if (Out_valid) begin
                valid_cyc_log.push_back(c);
                valid_data_log.push_back(Out_data);
            end
            if (Out_valid && Out_ready) begin
                hs_data_log.push_back(Out_data);
                hs_last_log.push_back(Out_last);
                hs_cyc_log.push_back(c);
            end
            if (Done) done_cyc_log.push_back(c);

            if (e_done == 1) m_busy = 0;
            if (e_busy == 0 && Start) begin
                m_busy = 1;
                if (Count == 0) begin
                    m_done_cyc = c + 1;
                end else begin
                    m_addr      = First_addr;
                    m_left      = (Count > DEPTH) ? DEPTH : Count;
                    m_rd_cyc    = c + 1;
                    m_valid_frm = c + 3;
                end
            end else if (e_valid == 1 && Out_ready) begin
                if (m_left == 1) begin
                    m_valid_frm = -1;
                    m_done_cyc  = c + 1;
                end else begin
                    m_addr      = (m_addr + 1) % DEPTH;
                    m_left      = m_left - 1;
                    m_rd_cyc    = c + 1;
                    m_valid_frm = c + 3;
                end
            end
        end
    end

    int start_cyc;

    // Runs one burst. The ready mode is 0 for tied high, 1 for random, and
    // 2 for a five-cycle stall on the second word. The optional poke drives
    // Start mid-burst so the bench can confirm it is ignored.
    task automatic applyStimulus(input int first, input int count, input int mode, input bit poke);
        int done_before;
        bit finished;
        done_before = done_cyc_log.size();
        finished    = 0;
        @(posedge Clock); #1;
        Start      = 1'b1;
        First_addr = 3'(first);
        Count      = 4'(count);
        Out_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        start_cyc  = cyc;
        @(negedge Clock);
        for (int k = 0; k < 200 && !finished; k++) begin
            @(posedge Clock); #1;
            Start      = (poke && cyc == start_cyc + 4) ? 1'b1 : 1'b0;
            First_addr = 3'($urandom_range(0, 7));
            Count      = 4'($urandom_range(1, 15));
            case (mode)
                1:       Out_ready = 1'($urandom_range(0, 1));
                2:       Out_ready = (cyc >= start_cyc + 6 && cyc <= start_cyc + 10) ? 1'b0 : 1'b1;
                default: Out_ready = 1'b1;
            endcase
            @(negedge Clock);
            if (done_cyc_log.size() > done_before) finished = 1;
        end
        if (!finished) checkOutput("burst_timeout", 0, 1);
        Start = 1'b0;
    endtask

    task automatic checkSeq(input string name, input int got[$], input int exp_vals[$]);
        checkOutput({name, "_len"}, got.size(), exp_vals.size());
        for (int i = 0; i < exp_vals.size() && i < got.size(); i++)
            checkOutput(name, got[i], exp_vals[i]);
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int cnt12;
        Clear      = 1'b0;
        Start      = 1'b0;
        First_addr = '0;
        Count      = '0;
        Out_ready  = 1'b0;
        #1;
        checkOutput("reset_rd_en", Rd_en, 0);
        checkOutput("reset_rd_addr", Rd_addr, 0);
        checkOutput("reset_out_data", Out_data, 0);
        checkOutput("reset_out_valid", Out_valid, 0);
        checkOutput("reset_out_last", Out_last, 0);
        checkOutput("reset_busy", Busy, 0);
        checkOutput("reset_done", Done, 0);
        @(posedge Clock); @(posedge Clock); #3;
        Clear = 1'b1;

        // The block must stay idle with Start low.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            checkOutput("idle_busy", Busy, 0);
        end

        // Basic burst.
        $display("[TB] basic burst");
        clearLogs();
        applyStimulus(2, 3, 0, 0);
        checkSeq("basic_rd_addr", rd_addr_log, '{2, 3, 4});
        checkSeq("basic_data", hs_data_log, '{13, 12, 11});
        checkSeq("basic_last", hs_last_log, '{0, 0, 1});
        checkOutput("basic_done_count", done_cyc_log.size(), 1);
        if (rd_cyc_log.size() > 0) checkOutput("basic_rd_latency", rd_cyc_log[0] - start_cyc, 1);
        if (valid_cyc_log.size() > 0) checkOutput("basic_valid_latency", valid_cyc_log[0] - start_cyc, 3);
        if (done_cyc_log.size() > 0 && hs_cyc_log.size() > 0)
            checkOutput("basic_done_after_hs", done_cyc_log[0] - hs_cyc_log[hs_cyc_log.size()-1], 1);

        // Backpressure on the second word.
        $display("[TB] backpressure");
        clearLogs();
        applyStimulus(2, 3, 2, 0);
        checkSeq("bp_data", hs_data_log, '{13, 12, 11});
        checkOutput("bp_rd_count", rd_addr_log.size(), 3);
        cnt12 = 0;
        foreach (valid_data_log[i]) if (valid_data_log[i] == 12) cnt12++;
        checkOutput("bp_word12_valid_cycles", cnt12, 6);

        // Wrap-around at the top of the file.
        $display("[TB] wrap");
        clearLogs();
        applyStimulus(6, 3, 0, 0);
        checkSeq("wrap_rd_addr", rd_addr_log, '{6, 7, 0});
        checkSeq("wrap_data", hs_data_log, '{9, 8, 15});

        // A Count above the file depth is clamped to eight words.
        $display("[TB] clamp");
        clearLogs();
        applyStimulus(5, 12, 0, 0);
        checkOutput("clamp_words", hs_data_log.size(), 8);
        checkSeq("clamp_last", hs_last_log, '{0, 0, 0, 0, 0, 0, 0, 1});
        checkOutput("clamp_done_count", done_cyc_log.size(), 1);

        // A zero Count produces only a Done pulse.
        $display("[TB] zero count");
        clearLogs();
        applyStimulus(3, 0, 0, 0);
        checkOutput("zero_rd_count", rd_addr_log.size(), 0);
        checkOutput("zero_valid_count", valid_cyc_log.size(), 0);
        if (done_cyc_log.size() > 0) checkOutput("zero_done_latency", done_cyc_log[0] - start_cyc, 1);

        // A Start pulse while busy is ignored.
        $display("[TB] start while busy");
        clearLogs();
        applyStimulus(0, 3, 0, 1);
        checkSeq("busy_start_rd_addr", rd_addr_log, '{0, 1, 2});
        checkOutput("busy_start_done_count", done_cyc_log.size(), 1);
        repeat (4) @(negedge Clock);
        checkOutput("busy_start_idle_after", Busy, 0);

        // Reset mid-burst.
        $display("[TB] reset mid-burst");
        clearLogs();
        @(posedge Clock); #1;
        Start = 1'b1; First_addr = 3'd0; Count = 4'd4; Out_ready = 1'b0;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int k = 0; k < 10 && !Out_valid; k++) @(negedge Clock);
        checkOutput("rst_reached_send", Out_valid, 1);
        @(posedge Clock); #3;
        Clear = 1'b0;
        #1;
        checkOutput("rst_async_valid", Out_valid, 0);
        checkOutput("rst_async_busy", Busy, 0);
        checkOutput("rst_async_rd_en", Rd_en, 0);
        checkOutput("rst_async_out_data", Out_data, 0);
        checkOutput("rst_async_done", Done, 0);
        @(posedge Clock); @(posedge Clock); #3;
        Clear = 1'b1; Out_ready = 1'b1;
        repeat (3) @(negedge Clock);
        checkOutput("rst_no_done", done_cyc_log.size(), 0);
        clearLogs();
        applyStimulus(1, 2, 0, 0);
        checkSeq("rst_after_data", hs_data_log, '{14, 13});

        // Random bursts that only the reference model checks.
        $display("[TB] random bursts");
        for (int r = 0; r < 12; r++) begin
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 15), 1, r[0]);
        end
        repeat (3) @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_burst_reader.md
Name: regfile_burst_reader

Overview:
- Read-side sequencer for the N-bit register file.
- On Start, it walks a contiguous range of register addresses through the file's synchronous read port.
- Each word read is presented on a valid/ready output stream; Out_last marks the final word and Done pulses at the end.
- Sits between the register file read port and any consumer: debug dump, bus bridge or checksum unit.

Parameters:
- N, 4, data width of each register word.
- ADDR_W, 3, register address width; the file holds 2^ADDR_W registers.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Clear  input  1  asynchronous active-low reset.
- Start  input  1  request a burst; sampled only in IDLE.
- First_addr  input  ADDR_W  address of the first register to read; sampled with Start.
- Count  input  ADDR_W+1  number of registers to read; sampled with Start.
- Rd_en  output  1  read enable to the register file.
- Rd_addr  output  ADDR_W  read address to the register file.
- Rd_data  input  N  register file read data; valid the cycle after Rd_en.
- Out_data  output  N  streamed word.
- Out_valid  output  1  Out_data is valid.
- Out_ready  input  1  consumer accepts the word.
- Out_last  output  1  current word is the final word of the burst.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset (Clear=0, asynchronous): state=IDLE; Rd_en, Out_valid, Out_last, Busy, Done = 0; Rd_addr, Out_data, the address register and the remaining counter = 0. Outputs drop immediately, not at the next edge.
- Reset mid-burst: the burst is abandoned; the word in flight is lost; no Done pulse.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- States: IDLE, ISSUE, CAPTURE, SEND, FINISH.
- IDLE:
  - Start=1 and Count!=0: latch addr=First_addr and rem=min(Count, 2^ADDR_W); go to ISSUE.
  - Start=1 and Count=0: go to FINISH with no reads.
  - Otherwise stay in IDLE.
- ISSUE: Rd_en=1, Rd_addr=addr for exactly one cycle; go to CAPTURE.
- CAPTURE: at the edge ending this state, Out_data<=Rd_data; go to SEND.
- SEND:
  - Out_valid=1; Out_last=1 when rem==1.
  - Out_data is held stable until the handshake.
  - Handshake occurs at a rising edge with Out_valid=1 and Out_ready=1.
  - On handshake with rem==1: go to FINISH.
  - On handshake with rem>1: addr<=addr+1 (modulo 2^ADDR_W, so it wraps 2^ADDR_W-1 -> 0), rem<=rem-1; go to ISSUE.
  - Out_ready=0 holds SEND indefinitely with outputs unchanged.
- FINISH: Done=1 for one cycle; go to IDLE.
- Latency: Start edge -> Rd_en next cycle -> Out_valid two cycles after Rd_en.
- Peak rate is one word per 3 cycles with Out_ready tied high.
- Out_ready asserted while Out_valid=0 has no effect.
- Start while Busy=1 is ignored, as are changes to First_addr or Count mid-burst.
- Count greater than 2^ADDR_W is clamped, so each register is read at most once per burst.

Test Plan:
- Common setup for all scenarios: N=4, ADDR_W=3; register file preloaded with reg[i]=15-i.
- Reset then idle: Clear=0 then Clear=1, Start=0 -> all outputs 0; Busy=0 for 10 cycles.
- Basic burst: First_addr=2, Count=3, Out_ready=1.
  - Rd_addr sequence is 2, 3, 4.
  - Out_data sequence is 13, 12, 11.
  - Out_last is high with 11 only; Done pulses once, 1 cycle after the last handshake.
  - Rd_en first rises 1 cycle after Start; first Out_valid appears 3 cycles after Start.
- Backpressure: same burst with Out_ready=0 for 5 cycles on the second word -> Out_data=12 is held stable and Out_valid stays high; no extra Rd_en pulse; the sequence completes unchanged.
- Wrap and clamp:
  - First_addr=6, Count=3 -> Rd_addr 6, 7, 0; data 9, 8, 15.
  - Count=12 -> exactly 8 words, then Done.
- Count=0 and Start while Busy:
  - Count=0 -> Done pulses 1 cycle after Start; no Rd_en; no Out_valid.
  - A Start pulse mid-burst is ignored.
- Reset mid-burst: Clear=0 while in SEND -> Out_valid and Busy drop asynchronously; no Done pulse; a new Start after release runs a normal burst.
